traffic_sensor_ctrl: RTL and testbench
======================================

Name: traffic_sensor_ctrl

Overview:
- Vehicle-detection front end for the two-street traffic-light controller. It is the producer of that controller's Ta/Tb inputs and the consumer of its La/Lb outputs.
- Per street, it synchronises and debounces a raw loop-detector signal and keeps a saturating queue count of waiting cars.
- Cars are drained from a street's queue only while that street's light is GREEN.
- Ta/Tb assert whenever the corresponding queue is non-empty.

Parameters:
- DEB_CYCLES, 3, consecutive synchronised-high cycles needed to accept one arrival (>=1).
- DEPART_CYCLES, 4, cycles of continuous GREEN per departing car (>=1).
- QMAX, 7, saturation value of each queue counter.
- QW, $clog2(QMAX+1), queue counter width (derived; not overridden).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- det_a  in  1  raw asynchronous loop detector, street A.
- det_b  in  1  raw asynchronous loop detector, street B.
- La  in  2  light state, street A (light_t).
- Lb  in  2  light state, street B (light_t).
- Ta  out  1  traffic present on A: (queue_a != 0).
- Tb  out  1  traffic present on B: (queue_b != 0).
- queue_a  out  QW  cars waiting on A.
- queue_b  out  QW  cars waiting on B.
- ovf_a  out  1  sticky: an arrival on A was dropped at QMAX.
- ovf_b  out  1  sticky: an arrival on B was dropped at QMAX.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high. While rst=1, all registers clear immediately: synchronisers, debounce FSMs (IDLE), debounce and departure counters, queue_a/queue_b=0, ovf_a/ovf_b=0, Ta/Tb=0.
- Reset mid-operation discards queued cars, in-progress debounces and partial departure timers. The only exception is the sticky ovf flags, which are cleared by reset alone.
- Light encoding: GREEN=2'b00, YELLOW=2'b01, RED=2'b10. 2'b11 is treated as RED.
- Synchroniser: two flops per det_x; sync2 is the debounced input.
- Debounce FSM, per street:
  - IDLE: if sync2=1, cnt<=1; if DEB_CYCLES==1, emit arrival and go HELD, else go CONFIRM.
  - CONFIRM: if sync2=0, go IDLE (glitch rejected). Else cnt<=cnt+1; when cnt+1==DEB_CYCLES, emit arrival and go HELD.
  - HELD: stay until sync2=0, then go IDLE. A held-high detector counts exactly one car.
- Arrival pulse: registered, one cycle wide.
- Latency: det_x rises before edge k and stays high; queue_x increments at edge k+2+DEB_CYCLES.
- Departure timer, per street:
  - Counts while light_x==GREEN and queue_x>0.
  - On reaching DEPART_CYCLES it emits a departure pulse and restarts at 0.
  - It is cleared whenever light_x!=GREEN or queue_x==0. Yellow does not drain.
- Queue update each edge:
  - arrival only: +1 if <QMAX; otherwise unchanged and ovf_x<=1.
  - departure only: -1 (departure requires queue>0, so no underflow).
  - both in the same cycle: unchanged, and no ovf even at QMAX.
- Ta/Tb: driven combinationally from the queue registers, so they are glitch-free. They change in the same cycle the queue crosses 0.
- Streets A and B are fully independent; no cross-street interaction.

Decomposition:
- Package traffic_pkg:
  - light_t enum {GREEN=2'b00, YELLOW=2'b01, RED=2'b10}.
  - deb_state_t enum {IDLE, CONFIRM, HELD}.
- Sub-module lane_sensor: one per street, containing synchroniser, debounce FSM, departure timer, queue and ovf.
  - Ports: clk, rst, det, light, present, queue, ovf.
  - traffic_sensor_ctrl instantiates it twice and maps present to Ta/Tb.

Test Plan:
- Reset mid-count: queue_a=3, ovf_a=1, assert rst between edges. Expect queue_a=0, Ta=0, ovf_a=0 immediately, before the next edge. After release, no phantom arrival.
- Single arrival: defaults, La=RED. det_a high 6 cycles from before edge k. Expect queue_a 0->1 at edge k+5, Ta=1; det_b path unaffected.
- Glitch rejection: det_a high for 2 cycles only (< DEB_CYCLES=3). Expect queue_a stays 0, Ta stays 0. Repeat with det_a held 20 cycles and expect exactly one count.
- Drain on green: queue_a=3, La switches RED->GREEN at edge g. Expect queue_a 2, 1, 0 at edges g+4, g+8, g+12 and Ta falls at g+12. Switch La=YELLOW at g+6: expect queue_a stays 2 and the timer restarts from 0 on the next GREEN.
- Saturation: QMAX=7, La=RED, 8 clean arrivals. Expect queue_a=7 after the 7th; on the 8th, queue_a stays 7 and ovf_a=1 and stays set.
- Simultaneous events: queue_b=2, Lb=GREEN, arrival pulse timed to coincide with the departure edge. Expect queue_b stays 2 for that edge, then 1 after the next departure.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared types for the traffic-light sensor front end: light encoding seen from
// the light controller and the per-street debounce state.
package traffic_pkg;

    typedef enum logic [1:0] {
        GREEN  = 2'b00,
        YELLOW = 2'b01,
        RED    = 2'b10
    } light_t;

    typedef enum logic [1:0] {
        IDLE,
        CONFIRM,
        HELD
    } deb_state_t;

endpackage

// File: rtl/lane_sensor.sv
// One street: detector synchroniser and debounce, departure timer driven by the
// street's light, and a saturating count of waiting cars with a sticky overflow.
module lane_sensor
    import traffic_pkg::*;
#(
    parameter int  DEB_CYCLES    = 3,
    parameter int  DEPART_CYCLES = 4,
    parameter int  QMAX          = 7,
    localparam int QW            = $clog2(QMAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          det,
    input  light_t        light,
    output logic          present,
    output logic [QW-1:0] queue,
    output logic          ovf
);

    localparam int              DW       = $clog2(DEB_CYCLES + 1);
    localparam int              TW       = $clog2(DEPART_CYCLES + 1);
    localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_CYCLES - 1);
    localparam logic [TW-1:0]   DEP_LAST = TW'(DEPART_CYCLES - 1);
    localparam logic [QW-1:0]   Q_FULL   = QW'(QMAX);

    logic [1:0]    sync_q;
    deb_state_t    state_q, state_d;
    logic [DW-1:0] cnt_q, cnt_d;
    logic          arrival_q, arrival_d;
    logic [TW-1:0] tmr_q, tmr_d;
    logic [QW-1:0] queue_q, queue_d;
    logic          ovf_q, ovf_d;
    logic          green;
    logic          depart;

    // NOTE: every register uses <= so all flops sample pre-edge values together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q    <= '0;
            state_q   <= IDLE;
            cnt_q     <= '0;
            arrival_q <= 1'b0;
            tmr_q     <= '0;
            queue_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], det};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arrival_q <= arrival_d;
            tmr_q     <= tmr_d;
            queue_q   <= queue_d;
            ovf_q     <= ovf_d;
        end
    end

    // NOTE: every output of a combinational block is defaulted first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        arrival_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync_q[1]) begin
                    cnt_d = DW'(1);
                    if (DEB_CYCLES == 1) begin
                        arrival_d = 1'b1;
                        state_d   = HELD;
                    end else begin
                        state_d = CONFIRM;
                    end
                end
            end
            CONFIRM: begin
                if (!sync_q[1]) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + DW'(1);
                    if (cnt_q == DEB_LAST) begin
                        arrival_d = 1'b1;
                        state_d   = HELD;
                    end
                end
            end
            HELD: begin
                if (!sync_q[1]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // An arrival and a departure in the same cycle cancel, so neither moves the count nor flags overflow.
    always_comb begin
        green   = (light == GREEN);
        depart  = green && (queue_q != '0) && (tmr_q == DEP_LAST);
        tmr_d   = tmr_q + TW'(1);
        queue_d = queue_q;
        ovf_d   = ovf_q;
        if (!green || (queue_q == '0) || depart) tmr_d = '0;
        if (arrival_q && !depart) begin
            if (queue_q < Q_FULL) queue_d = queue_q + QW'(1);
            else                  ovf_d   = 1'b1;
        end else if (depart && !arrival_q) begin
            queue_d = queue_q - QW'(1);
        end
    end

    assign present = (queue_q != '0);
    assign queue   = queue_q;
    assign ovf     = ovf_q;

endmodule

// File: rtl/traffic_sensor_ctrl.sv
// Vehicle-detection front end: two independent lane sensors producing the
// Ta/Tb traffic-present inputs of the two-street light controller.
module traffic_sensor_ctrl
    import traffic_pkg::*;
#(
    parameter int  DEB_CYCLES    = 3,
    parameter int  DEPART_CYCLES = 4,
    parameter int  QMAX          = 7,
    localparam int QW            = $clog2(QMAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          det_a,
    input  logic          det_b,
    input  light_t        La,
    input  light_t        Lb,
    output logic          Ta,
    output logic          Tb,
    output logic [QW-1:0] queue_a,
    output logic [QW-1:0] queue_b,
    output logic          ovf_a,
    output logic          ovf_b
);

    lane_sensor #(
        .DEB_CYCLES    (DEB_CYCLES),
        .DEPART_CYCLES (DEPART_CYCLES),
        .QMAX          (QMAX)
    ) u_lane_a (
        .clk     (clk),
        .rst     (rst),
        .det     (det_a),
        .light   (La),
        .present (Ta),
        .queue   (queue_a),
        .ovf     (ovf_a)
    );

    lane_sensor #(
        .DEB_CYCLES    (DEB_CYCLES),
        .DEPART_CYCLES (DEPART_CYCLES),
        .QMAX          (QMAX)
    ) u_lane_b (
        .clk     (clk),
        .rst     (rst),
        .det     (det_b),
        .light   (Lb),
        .present (Tb),
        .queue   (queue_b),
        .ovf     (ovf_b)
    );

endmodule

// File: tb/tb_traffic_sensor_ctrl.sv
// Scoreboard bench for traffic_sensor_ctrl: each stimulus step schedules the
// expected output values at specific clock edges; a negedge checker compares them.
module tb_traffic_sensor_ctrl;
    import traffic_pkg::*;

    localparam int QW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          det_a, det_b;
    light_t        La, Lb;
    logic          Ta, Tb;
    logic [QW-1:0] queue_a, queue_b;
    logic          ovf_a, ovf_b;

    traffic_sensor_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .det_a   (det_a),
        .det_b   (det_b),
        .La      (La),
        .Lb      (Lb),
        .Ta      (Ta),
        .Tb      (Tb),
        .queue_a (queue_a),
        .queue_b (queue_b),
        .ovf_a   (ovf_a),
        .ovf_b   (ovf_b)
    );

    always #5 clk = ~clk;

    typedef enum {S_QA, S_QB, S_TA, S_TB, S_OA, S_OB} sig_t;
    typedef struct {
        string tag;
        int    at;
        sig_t  sig;
        int    exp;
    } exp_t;

    exp_t sb[$];
    int   edge_n = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    function automatic logic [31:0] observe(input sig_t s);
        case (s)
            S_QA:    return 32'(queue_a);
            S_QB:    return 32'(queue_b);
            S_TA:    return 32'(Ta);
            S_TB:    return 32'(Tb);
            S_OA:    return 32'(ovf_a);
            default: return 32'(ovf_b);
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    // Expected value of a signal as seen after the edge 'dly' edges from now.
    task automatic expect_at(input string tag, input int dly, input sig_t s, input int v);
        exp_t e;
        e.tag = tag;
        e.at  = edge_n + dly;
        e.sig = s;
        e.exp = v;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].at == edge_n) begin
                check(sb[i].tag, observe(sb[i].sig), 32'(sb[i].exp));
                sb.delete(i);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One clean car: detector high for 'hold' edges, then low long enough to re-arm.
    task automatic car(input bit on_b, input int hold);
        if (on_b) det_b = 1'b1; else det_a = 1'b1;
        step(hold);
        if (on_b) det_b = 1'b0; else det_a = 1'b0;
        step(4);
    endtask

    task automatic reset_pulse(input string tag);
        #2;
        rst = 1'b1;
        #1;
        check({tag, "_qa"}, 32'(queue_a), 0);
        check({tag, "_ta"}, 32'(Ta), 0);
        check({tag, "_oa"}, 32'(ovf_a), 0);
        check({tag, "_qb"}, 32'(queue_b), 0);
        check({tag, "_ob"}, 32'(ovf_b), 0);
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        int guard;
        rst   = 1'b1;
        det_a = 1'b0;
        det_b = 1'b0;
        La    = RED;
        Lb    = RED;
        #2;
        check("rst_qa", 32'(queue_a), 0);
        check("rst_ta", 32'(Ta), 0);
        check("rst_tb", 32'(Tb), 0);
        check("rst_oa", 32'(ovf_a), 0);
        step(2);
        rst = 1'b0;
        step(1);

        // Single arrival: count appears exactly DEB_CYCLES+2 edges after the rise.
        expect_at("arr_qa_early", 5, S_QA, 0);
        expect_at("arr_qa", 6, S_QA, 1);
        expect_at("arr_ta", 6, S_TA, 1);
        expect_at("arr_qb", 6, S_QB, 0);
        expect_at("arr_tb", 6, S_TB, 0);
        car(1'b0, 6);
        step(2);

        // Two-cycle glitch is rejected; a 20-cycle hold counts once.
        expect_at("glitch_qa", 12, S_QA, 1);
        det_a = 1'b1;
        step(2);
        det_a = 1'b0;
        step(12);
        expect_at("hold_qa_early", 5, S_QA, 1);
        expect_at("hold_qa", 6, S_QA, 2);
        expect_at("hold_qa_end", 24, S_QA, 2);
        det_a = 1'b1;
        step(20);
        det_a = 1'b0;
        step(6);

        // Saturation from empty: eighth arrival is dropped and sets ovf_a.
        reset_pulse("rst_sat");
        step(1);
        for (int i = 1; i <= 8; i++) begin
            expect_at($sformatf("sat_qa_%0d", i), 6, S_QA, (i > 7) ? 7 : i);
            expect_at($sformatf("sat_oa_%0d", i), 6, S_OA, (i == 8) ? 1 : 0);
            car(1'b0, 6);
        end
        expect_at("sat_oa_sticky", 10, S_OA, 1);
        step(10);

        // Drain on green: one car per DEPART_CYCLES, 7 down to 3.
        expect_at("drain_qa_g3", 3, S_QA, 7);
        expect_at("drain_qa_g4", 4, S_QA, 6);
        expect_at("drain_qa_g8", 8, S_QA, 5);
        expect_at("drain_qa_g12", 12, S_QA, 4);
        expect_at("drain_qa_g16", 16, S_QA, 3);
        expect_at("drain_oa_g16", 16, S_OA, 1);
        La = GREEN;
        step(16);
        La = RED;
        expect_at("red_hold_qa", 6, S_QA, 3);
        step(8);

        // Reset mid-operation clears queue, Ta and the sticky flag at once; no phantom arrival.
        check("pre_rst_qa", 32'(queue_a), 3);
        check("pre_rst_oa", 32'(ovf_a), 1);
        reset_pulse("rst_mid");
        expect_at("post_rst_qa", 10, S_QA, 0);
        expect_at("post_rst_ta", 10, S_TA, 0);
        expect_at("post_rst_oa", 10, S_OA, 0);
        step(12);

        // Yellow interrupts the drain and the departure timer starts over.
        for (int i = 1; i <= 3; i++) begin
            expect_at($sformatf("fill_qa_%0d", i), 6, S_QA, i);
            car(1'b0, 6);
        end
        expect_at("yel_qa_g3", 3, S_QA, 3);
        expect_at("yel_qa_g4", 4, S_QA, 2);
        expect_at("yel_qa_g12", 12, S_QA, 2);
        La = GREEN;
        step(6);
        La = YELLOW;
        step(8);
        expect_at("regreen_qa_h3", 3, S_QA, 2);
        expect_at("regreen_qa_h4", 4, S_QA, 1);
        expect_at("regreen_qa_h7", 7, S_QA, 1);
        expect_at("regreen_ta_h7", 7, S_TA, 1);
        expect_at("regreen_qa_h8", 8, S_QA, 0);
        expect_at("regreen_ta_h8", 8, S_TA, 0);
        expect_at("regreen_oa", 8, S_OA, 0);
        La = GREEN;
        step(10);

        // Street B: arrival coincides with a departure edge, so the count holds.
        for (int i = 1; i <= 2; i++) begin
            expect_at($sformatf("fill_qb_%0d", i), 6, S_QB, i);
            car(1'b1, 6);
        end
        expect_at("sim_qb_g3", 5, S_QB, 2);
        expect_at("sim_qb_g4", 6, S_QB, 2);
        expect_at("sim_qb_g7", 9, S_QB, 2);
        expect_at("sim_qb_g8", 10, S_QB, 1);
        expect_at("sim_ob", 10, S_OB, 0);
        expect_at("sim_qa", 10, S_QA, 0);
        det_b = 1'b1;
        step(2);
        Lb = GREEN;
        step(4);
        det_b = 1'b0;
        step(4);

        // Encoding 2'b11 behaves as red: no draining.
        Lb = light_t'(2'b11);
        expect_at("lb11_qb", 12, S_QB, 1);
        expect_at("lb11_tb", 12, S_TB, 1);
        step(14);

        guard = 0;
        while (sb.size() > 0 && guard < 50) begin
            step(1);
            guard++;
        end
        check("sb_drained", 32'(sb.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
